// File: rtl/ether_axil_slave.sv
// ----------------------------------------------------------------------------
// ether_axil_slave
//   AXI4-Lite responder holding a bank of 32-bit control/status registers for
//   the ethernetlite subsystem. One slot (RO_IDX) is a read-only view of the
//   hardware status word; all other slots are read/write with byte strobes.
//
// Ports
//   sys_clk, arst         : clock (rising edge) and async active-high reset
//   aw*/w*/b*             : AXI4-Lite write address / data / response channels
//   ar*/r*                : AXI4-Lite read address / data channels
//   status_in             : hardware status, sampled when RO_IDX is read
//   regs_out              : flat export of register k at [32k+31:32k];
//                           the RO_IDX slot drives zero
// ----------------------------------------------------------------------------
module ether_axil_slave #(
  parameter int          NUM_REGS  = 8,
  parameter int          RO_IDX    = 7,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     sys_clk,
  input  logic                     arst,
  input  logic [31:0]              awaddr,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [1:0]               rresp,
  input  logic [31:0]              status_in,
  output logic [32*NUM_REGS-1:0]   regs_out
);

  localparam int             IW     = $clog2(NUM_REGS);
  localparam logic [IW-1:0]  RO_I   = IW'(RO_IDX);
  localparam logic [29:0]    NUM_W  = 30'(NUM_REGS);
  localparam logic [1:0]     OKAY   = 2'b00;
  localparam logic [1:0]     SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  typedef enum logic {
    R_IDLE  = 1'b0,
    R_VALID = 1'b1
  } rstate_t;

  // Replace only the strobed bytes of the old value.
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        res[8*b +: 8] = new_v[8*b +: 8];
      end else begin
        res[8*b +: 8] = old_v[8*b +: 8];
      end
    end
    return res;
  endfunction

  logic [31:0] r_regs [NUM_REGS];

  // Write channel state
  wstate_t     r_wstate;
  logic [29:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_awready;
  logic        r_wready;
  logic        r_bvalid;
  logic [1:0]  r_bresp;

  // Read channel state
  rstate_t     r_rstate;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  logic        w_aw_hs;
  logic        w_w_hs;
  logic        w_ar_hs;
  logic        w_commit;
  logic [29:0] w_caddr;
  logic [31:0] w_cdata;
  logic [3:0]  w_cstrb;
  logic [IW-1:0] w_cidx;
  logic        w_cslverr;
  logic [29:0] w_raddr;
  logic [IW-1:0] w_ridx;
  logic        w_roor;
  logic [31:0] w_rdata_src;

  // Byte-offset address bits carry no meaning for a word-wide register bank.
  logic        w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{awaddr[1:0], araddr[1:0]};

  // Handshakes use registered readies, so no input reaches an output combinationally.
  assign w_aw_hs = awvalid & r_awready;
  assign w_w_hs  = wvalid  & r_wready;
  assign w_ar_hs = arvalid & r_arready;

  // Select the address/data pair for a commit: whichever half arrived earlier comes from its latch.
  always_comb begin
    w_commit = 1'b0;
    w_caddr  = r_awaddr;
    w_cdata  = r_wdata;
    w_cstrb  = r_wstrb;
    case (r_wstate)
      W_IDLE: begin
        w_commit = w_aw_hs & w_w_hs;
        w_caddr  = awaddr[31:2];
        w_cdata  = wdata;
        w_cstrb  = wstrb;
      end
      W_ADDR: begin
        w_commit = w_w_hs;
        w_cdata  = wdata;
        w_cstrb  = wstrb;
      end
      W_DATA: begin
        w_commit = w_aw_hs;
        w_caddr  = awaddr[31:2];
      end
      default: begin
        w_commit = 1'b0;
      end
    endcase
  end

  assign w_cidx    = w_caddr[IW-1:0];
  assign w_cslverr = (w_caddr >= NUM_W) || (w_cidx == RO_I);

  assign w_raddr = araddr[31:2];
  assign w_ridx  = w_raddr[IW-1:0];
  assign w_roor  = (w_raddr >= NUM_W);

  // Read data source: zero when out of range, live status for the RO slot, else the stored word.
  always_comb begin
    w_rdata_src = 32'h0000_0000;
    if (w_roor) begin
      w_rdata_src = 32'h0000_0000;
    end else if (w_ridx == RO_I) begin
      w_rdata_src = status_in;
    end else begin
      w_rdata_src = r_regs[w_ridx];
    end
  end

  // Write FSM, register bank and write response channel.
  always_ff @(posedge sys_clk or posedge arst) begin
    if (arst) begin
      r_wstate  <= W_IDLE;
      r_awaddr  <= 30'h0;
      r_wdata   <= 32'h0;
      r_wstrb   <= 4'h0;
      r_awready <= 1'b1;
      r_wready  <= 1'b1;
      r_bvalid  <= 1'b0;
      r_bresp   <= 2'b00;
      for (int k = 0; k < NUM_REGS; k++) begin
        r_regs[k] <= RESET_VAL;
      end
    end else if (w_commit) begin
      if (!w_cslverr) begin
        r_regs[w_cidx] <= merge_bytes(r_regs[w_cidx], w_cdata, w_cstrb);
      end
      r_bresp   <= w_cslverr ? SLVERR : OKAY;
      r_bvalid  <= 1'b1;
      r_awready <= 1'b0;
      r_wready  <= 1'b0;
      r_wstate  <= W_RESP;
    end else begin
      case (r_wstate)
        W_IDLE: begin
          if (w_aw_hs) begin
            r_awaddr  <= awaddr[31:2];
            r_awready <= 1'b0;
            r_wstate  <= W_ADDR;
          end else if (w_w_hs) begin
            r_wdata  <= wdata;
            r_wstrb  <= wstrb;
            r_wready <= 1'b0;
            r_wstate <= W_DATA;
          end
        end
        W_ADDR, W_DATA: begin
          r_wstate <= r_wstate;
        end
        W_RESP: begin
          if (bready) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wstate  <= W_IDLE;
          end
        end
        default: begin
          r_bvalid  <= 1'b0;
          r_awready <= 1'b1;
          r_wready  <= 1'b1;
          r_wstate  <= W_IDLE;
        end
      endcase
    end
  end

  // Read FSM: capture data at the AR handshake and hold it until rready.
  always_ff @(posedge sys_clk or posedge arst) begin
    if (arst) begin
      r_rstate  <= R_IDLE;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rresp   <= 2'b00;
    end else begin
      case (r_rstate)
        R_IDLE: begin
          if (w_ar_hs) begin
            r_rdata   <= w_rdata_src;
            r_rresp   <= w_roor ? SLVERR : OKAY;
            r_rvalid  <= 1'b1;
            r_arready <= 1'b0;
            r_rstate  <= R_VALID;
          end
        end
        R_VALID: begin
          if (rready) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rstate  <= R_IDLE;
          end
        end
        default: begin
          r_rvalid  <= 1'b0;
          r_arready <= 1'b1;
          r_rstate  <= R_IDLE;
        end
      endcase
    end
  end

  assign awready = r_awready;
  assign wready  = r_wready;
  assign bvalid  = r_bvalid;
  assign bresp   = r_bresp;
  assign arready = r_arready;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_out
    if (k == RO_IDX) begin : g_ro
      assign regs_out[32*k +: 32] = 32'h0000_0000;
    end else begin : g_rw
      assign regs_out[32*k +: 32] = r_regs[k];
    end
  end

endmodule

// File: tb/tb_ether_axil_slave.sv
// ----------------------------------------------------------------------------
// tb_ether_axil_slave
//   Self-checking bench for ether_axil_slave. A word-array model of the
//   register bank predicts responses, read data and the regs_out export.
// ----------------------------------------------------------------------------
module tb_ether_axil_slave;

  localparam int NUM_REGS = 8;
  localparam int RO_IDX   = 7;

  logic                   sys_clk = 1'b0;
  logic                   arst;
  logic [31:0]            awaddr;
  logic                   awvalid;
  logic                   awready;
  logic [31:0]            wdata;
  logic [3:0]             wstrb;
  logic                   wvalid;
  logic                   wready;
  logic [1:0]             bresp;
  logic                   bvalid;
  logic                   bready;
  logic [31:0]            araddr;
  logic                   arvalid;
  logic                   arready;
  logic [31:0]            rdata;
  logic                   rvalid;
  logic                   rready;
  logic [1:0]             rresp;
  logic [31:0]            status_in;
  logic [32*NUM_REGS-1:0] regs_out;

  int vectors     = 0;
  int miscompares = 0;

  logic [31:0] model [NUM_REGS];

  always #5 sys_clk = ~sys_clk;

  ether_axil_slave #(
    .NUM_REGS (NUM_REGS),
    .RO_IDX   (RO_IDX),
    .RESET_VAL(32'h0000_0000)
  ) dut (
    .sys_clk  (sys_clk),
    .arst     (arst),
    .awaddr   (awaddr),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rvalid   (rvalid),
    .rready   (rready),
    .rresp    (rresp),
    .status_in(status_in),
    .regs_out (regs_out)
  );

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic bit addr_oor(input logic [31:0] a);
    return (a >> 2) >= 32'(NUM_REGS);
  endfunction

  // Apply a write to the model; returns the expected response code.
  function automatic logic [1:0] model_write(input logic [31:0] a, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] m;
    int          idx;
    m   = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    idx = int'(a[7:2]);
    if (addr_oor(a) || idx == RO_IDX) return 2'b10;
    model[idx] = (model[idx] & ~m) | (d & m);
    return 2'b00;
  endfunction

  task automatic check_regs(input string tag);
    logic [31:0] exp_v;
    for (int k = 0; k < NUM_REGS; k++) begin
      exp_v = (k == RO_IDX) ? 32'h0 : model[k];
      vectors++;
      if (regs_out[32*k +: 32] !== exp_v) begin
        miscompares++;
        $display("FAIL %s regs_out[%0d]: got %h expected %h", tag, k, regs_out[32*k +: 32], exp_v);
      end
    end
  endtask

  // Full write: AW offered at cycle ta, W at cycle tw, B accepted after bdelay cycles.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int ta, input int tw, input int bdelay, input string tag);
    bit         aw_done = 1'b0;
    bit         w_done  = 1'b0;
    bit         aw_hs;
    bit         w_hs;
    int         c = 0;
    logic [1:0] exp_resp;
    while (!(aw_done && w_done) && c < 40) begin
      if (!aw_done && c == ta) begin awaddr = a; awvalid = 1'b1; end
      if (!w_done && c == tw) begin wdata = d; wstrb = s; wvalid = 1'b1; end
      vectors++;
      if (aw_done && !w_done) begin
        if (awready !== 1'b0 || wready !== 1'b1) begin
          miscompares++;
          $display("FAIL %s addr-held ready: got aw=%b w=%b expected aw=0 w=1", tag, awready, wready);
        end
      end else if (w_done && !aw_done) begin
        if (wready !== 1'b0 || awready !== 1'b1) begin
          miscompares++;
          $display("FAIL %s data-held ready: got aw=%b w=%b expected aw=1 w=0", tag, awready, wready);
        end
      end else begin
        if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0) begin
          miscompares++;
          $display("FAIL %s idle: got aw=%b w=%b bvalid=%b expected 1 1 0", tag, awready, wready, bvalid);
        end
      end
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      c++;
      if (aw_hs) begin aw_done = 1'b1; awvalid = 1'b0; awaddr = $urandom(); end
      if (w_hs)  begin w_done  = 1'b1; wvalid  = 1'b0; wdata  = $urandom(); end
    end
    if (!(aw_done && w_done)) begin
      miscompares++;
      $display("FAIL %s handshake timeout: got aw_done=%b w_done=%b expected 1 1", tag, aw_done, w_done);
      awvalid = 1'b0;
      wvalid  = 1'b0;
      return;
    end
    exp_resp = model_write(a, d, s);
    vectors++;
    if (bvalid !== 1'b1 || bresp !== exp_resp) begin
      miscompares++;
      $display("FAIL %s bresp: got bvalid=%b bresp=%b expected 1 %b", tag, bvalid, bresp, exp_resp);
    end
    check_regs(tag);
    repeat (bdelay) begin
      tick();
      vectors++;
      if (bvalid !== 1'b1 || bresp !== exp_resp || awready !== 1'b0 || wready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s b hold: got bvalid=%b bresp=%b aw=%b w=%b expected 1 %b 0 0",
                 tag, bvalid, bresp, awready, wready, exp_resp);
      end
    end
    bready = 1'b1;
    tick();
    bready = 1'b0;
    vectors++;
    if (bvalid !== 1'b0 || awready !== 1'b1 || wready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s b release: got bvalid=%b aw=%b w=%b expected 0 1 1", tag, bvalid, awready, wready);
    end
  endtask

  // Full read: status_in changes right after the AR handshake to prove it was sampled there.
  task automatic axi_read(input logic [31:0] a, input logic [31:0] st, input int rdelay,
                          input string tag);
    bit          done = 1'b0;
    bit          hs;
    int          c = 0;
    logic [31:0] exp_d;
    logic [1:0]  exp_r;
    status_in = st;
    araddr    = a;
    arvalid   = 1'b1;
    while (!done && c < 40) begin
      hs = arready;
      tick();
      c++;
      if (hs) done = 1'b1;
    end
    arvalid   = 1'b0;
    araddr    = $urandom();
    status_in = ~st;
    if (!done) begin
      miscompares++;
      $display("FAIL %s ar timeout: got arready never high expected handshake", tag);
      return;
    end
    if (addr_oor(a)) begin
      exp_d = 32'h0; exp_r = 2'b10;
    end else if (int'(a[7:2]) == RO_IDX) begin
      exp_d = st; exp_r = 2'b00;
    end else begin
      exp_d = model[int'(a[7:2])]; exp_r = 2'b00;
    end
    for (int i = 0; i <= rdelay; i++) begin
      vectors++;
      if (rvalid !== 1'b1 || rdata !== exp_d || rresp !== exp_r || arready !== 1'b0) begin
        miscompares++;
        $display("FAIL %s read: got rvalid=%b rdata=%h rresp=%b arready=%b expected 1 %h %b 0",
                 tag, rvalid, rdata, rresp, arready, exp_d, exp_r);
      end
      if (i < rdelay) tick();
    end
    rready = 1'b1;
    tick();
    rready = 1'b0;
    vectors++;
    if (rvalid !== 1'b0 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL %s r release: got rvalid=%b arready=%b expected 0 1", tag, rvalid, arready);
    end
  endtask

  task automatic test_reset();
    arst = 1'b1;
    awaddr = 32'h0; awvalid = 1'b0; wdata = 32'h0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = 32'h0; arvalid = 1'b0; rready = 1'b0; status_in = 32'h0;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;
    repeat (2) tick();
    arst = 1'b0;
    tick();
    vectors++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset readies: got aw=%b w=%b ar=%b expected 1 1 1", awready, wready, arready);
    end
    vectors++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || bresp !== 2'b00 || rresp !== 2'b00 || rdata !== 32'h0) begin
      miscompares++;
      $display("FAIL reset resp: got bv=%b rv=%b bresp=%b rresp=%b rdata=%h expected all zero",
               bvalid, rvalid, bresp, rresp, rdata);
    end
    check_regs("reset");
  endtask

  task automatic test_write_read();
    axi_write(32'h04, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, "wr04");
    vectors++;
    if (regs_out[63:32] !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL wr04 slot1: got %h expected deadbeef", regs_out[63:32]);
    end
    axi_read(32'h04, 32'h0, 0, "rd04");
  endtask

  task automatic test_split_write();
    axi_write(32'h08, 32'hAAAA_AAAA, 4'hF, 0, 0, 0, "wr08_init");
    axi_write(32'h08, 32'h1122_3344, 4'b0101, 3, 0, 1, "wr08_split");
    vectors++;
    if (regs_out[95:64] !== 32'hAA22_AA44) begin
      miscompares++;
      $display("FAIL wr08_split slot2: got %h expected aa22aa44", regs_out[95:64]);
    end
    axi_write(32'h10, 32'hCAFE_F00D, 4'b1010, 0, 2, 0, "wr10_addr_first");
    axi_write(32'h14, 32'h1234_5678, 4'h0, 1, 1, 0, "wr14_nostrb");
  endtask

  task automatic test_ro_oor();
    axi_write(32'h1C, 32'hFFFF_FFFF, 4'hF, 0, 0, 0, "wr_ro");
    axi_write(32'h40, 32'h5555_5555, 4'hF, 0, 0, 0, "wr_oor");
    axi_read(32'h40, 32'h0, 0, "rd_oor");
    axi_read(32'h1C, 32'h5A5A_0001, 0, "rd_ro");
    axi_read(32'h0100_0004, 32'h0, 0, "rd_highbits");
  endtask

  // Same-edge write commit and read accept to one register, then 5 cycles of back-pressure.
  task automatic test_backpressure();
    logic [31:0] old_v;
    logic [31:0] new_v;
    logic [1:0]  exp_b;
    axi_write(32'h0C, 32'h0BAD_0C0C, 4'hF, 0, 0, 0, "bp_init");
    old_v = model[3];
    new_v = $urandom();
    awaddr = 32'h0C; awvalid = 1'b1; wdata = new_v; wstrb = 4'hF; wvalid = 1'b1;
    araddr = 32'h0C; arvalid = 1'b1;
    vectors++;
    if (awready !== 1'b1 || wready !== 1'b1 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp readies: got aw=%b w=%b ar=%b expected 1 1 1", awready, wready, arready);
    end
    tick();
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    exp_b = model_write(32'h0C, new_v, 4'hF);
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bvalid !== 1'b1 || bresp !== exp_b || rvalid !== 1'b1 || rdata !== old_v || rresp !== 2'b00 ||
          awready !== 1'b0 || wready !== 1'b0 || arready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp hold%0d: got bv=%b br=%b rv=%b rd=%h rr=%b aw=%b w=%b ar=%b expected 1 %b 1 %h 00 0 0 0",
                 i, bvalid, bresp, rvalid, rdata, rresp, awready, wready, arready, exp_b, old_v);
      end
      if (i < 5) tick();
    end
    check_regs("bp");
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    vectors++;
    if (bvalid !== 1'b0 || rvalid !== 1'b0 || awready !== 1'b1 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp release: got bv=%b rv=%b aw=%b ar=%b expected 0 0 1 1", bvalid, rvalid, awready, arready);
    end
  endtask

  task automatic test_reset_mid();
    awaddr = 32'h10; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    vectors++;
    if (awready !== 1'b0) begin
      miscompares++;
      $display("FAIL mid addr-held: got awready=%b expected 0", awready);
    end
    arst = 1'b1;
    #1;
    for (int k = 0; k < NUM_REGS; k++) model[k] = 32'h0;
    vectors++;
    if (awready !== 1'b1 || wready !== 1'b1 || bvalid !== 1'b0 || bresp !== 2'b00) begin
      miscompares++;
      $display("FAIL mid wreset: got aw=%b w=%b bv=%b br=%b expected 1 1 0 00", awready, wready, bvalid, bresp);
    end
    check_regs("mid_wreset");
    tick();
    arst = 1'b0;
    tick();
    araddr = 32'h04; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    vectors++;
    if (rvalid !== 1'b1) begin
      miscompares++;
      $display("FAIL mid rvalid: got %b expected 1", rvalid);
    end
    arst = 1'b1;
    #1;
    vectors++;
    if (rvalid !== 1'b0 || rdata !== 32'h0 || rresp !== 2'b00 || arready !== 1'b1) begin
      miscompares++;
      $display("FAIL mid rreset: got rv=%b rd=%h rr=%b ar=%b expected 0 0 00 1", rvalid, rdata, rresp, arready);
    end
    tick();
    arst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++;
      if (bvalid !== 1'b0 || rvalid !== 1'b0) begin
        miscompares++;
        $display("FAIL mid stray%0d: got bv=%b rv=%b expected 0 0", i, bvalid, rvalid);
      end
    end
    axi_write(32'h18, 32'h7777_1234, 4'hF, 0, 1, 0, "mid_wr");
    axi_read(32'h18, 32'h0, 1, "mid_rd");
  endtask

  task automatic test_random();
    int          r;
    logic [31:0] a;
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      if (r < 8) a = 32'(r * 4 + $urandom_range(0, 3));
      else if (r == 8) a = 32'h20 + 32'($urandom_range(0, 255));
      else a = $urandom();
      if ($urandom_range(0, 1) == 0) begin
        axi_write(a, $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                  $urandom_range(0, 3), $urandom_range(0, 2), "rnd_wr");
      end else begin
        axi_read(a, $urandom(), $urandom_range(0, 2), "rnd_rd");
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_split_write();
    test_ro_oor();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ether_axil_slave.md
Name: ether_axil_slave

Overview:
AXI4-Lite responder holding a bank of 32-bit control/status registers for the ethernetlite subsystem. It is the slave end of the same AXI4-Lite channel set the driver-side interface carries: the AW, W, B, AR and R channels. The five channels use the same signal names. Register contents are exported to the datapath as a flat bus. One read-only status word is sampled from hardware.

Parameters:
NUM_REGS, 8, number of 32-bit registers; legal 2..64.
RO_IDX, 7, index of the read-only status register; must be < NUM_REGS.
RESET_VAL, 32'h0000_0000, reset value of every RW register.

Ports:
sys_clk  input  1  system clock; all logic on rising edge.
arst  input  1  asynchronous, active-high reset.
awaddr  input  32  write address.
awvalid  input  1  write address valid.
awready  output  1  write address ready.
wdata  input  32  write data.
wstrb  input  4  byte strobes; bit i enables wdata[8i+7:8i].
wvalid  input  1  write data valid.
wready  output  1  write data ready.
bresp  output  2  write response: 2'b00 OKAY, 2'b10 SLVERR.
bvalid  output  1  write response valid.
bready  input  1  write response ready.
araddr  input  32  read address.
arvalid  input  1  read address valid.
arready  output  1  read address ready.
rdata  output  32  read data.
rvalid  output  1  read data valid.
rready  input  1  read data ready.
rresp  output  2  read response: OKAY or SLVERR.
status_in  input  32  hardware status; returned on reads of RO_IDX.
regs_out  output  32*NUM_REGS  register contents; reg k is at [32k+31:32k]; the RO_IDX slot drives 0.

Behaviour:
- Reset (arst high, asynchronous):
  - all RW registers = RESET_VAL;
  - awready=1, wready=1, arready=1;
  - bvalid=0, rvalid=0, bresp=0, rresp=0, rdata=0;
  - write and read FSMs return to IDLE.
- Reset asserted mid-transaction aborts it silently. No response is issued after reset deasserts.
- Decode:
  - word index = addr[7:2]; addr[1:0] and addr[31:8] are ignored for indexing.
  - Out of range when addr[31:2] >= NUM_REGS.
- Write FSM: W_IDLE, W_ADDR (address held), W_DATA (data held), W_RESP.
  - W_IDLE: awready=1, wready=1.
    - AW and W handshake in the same cycle: commit on that edge, go to W_RESP.
    - AW only: latch awaddr, go to W_ADDR.
    - W only: latch wdata/wstrb, go to W_DATA.
  - W_ADDR: awready=0, wready=1. On W handshake, commit and go to W_RESP.
  - W_DATA: wready=0, awready=1. On AW handshake, commit and go to W_RESP.
  - W_RESP: awready=0, wready=0, bvalid=1, bresp held stable. Leave when bvalid&&bready, returning to W_IDLE (awready/wready high the next cycle).
  - Commit updates only strobed bytes. The updated value is visible on regs_out the cycle after the commit edge; bvalid rises that same cycle.
  - Writes to RO_IDX or out-of-range addresses: no register change, bresp=SLVERR. All others return OKAY. wstrb=0 is a legal no-op returning OKAY.
- Read FSM: R_IDLE, R_VALID.
  - R_IDLE: arready=1. On AR handshake, register rdata/rresp and go to R_VALID (rvalid=1 the next cycle).
  - R_VALID: arready=0. rdata, rresp and rvalid stay stable until rready; then return to R_IDLE.
  - Throughput: at most one read per 2 cycles.
  - Read data sources:
    - in-range RW index: register value;
    - RO_IDX: status_in sampled at the AR handshake edge, rresp=OKAY;
    - out of range: rdata=0, rresp=SLVERR.
- Read and write channels are independent.
  - Same-edge AR accept and write commit to the same register: the read returns the pre-write value.
- Readiness never depends combinationally on valid inputs. No combinational path from any input to any output.

Test Plan:
- Reset then idle: awready=wready=arready=1, bvalid=rvalid=0, all regs_out slots 0.
- AW+W same cycle, addr 0x04, data 0xDEADBEEF, wstrb 4'hF: bvalid next cycle, bresp=00, regs_out[63:32]=0xDEADBEEF. Then read 0x04 returns 0xDEADBEEF with rresp=00.
- W 3 cycles before AW (addr 0x08, data 0x11223344, wstrb 4'b0101) onto reg value 0xAAAAAAAA: after B handshake, reg2=0xAA22AA44. While waiting in W_DATA, wready=0.
- Write 0x1C (RO_IDX) and write 0x40: both bresp=10 and registers unchanged. Read 0x40 gives rdata=0, rresp=10. Read 0x1C with status_in=0x5A5A0001 gives 0x5A5A0001, rresp=00.
- Back-pressure: hold bready=0 and rready=0 for 5 cycles. bvalid/rvalid and data stay stable; awready=wready=arready=0 throughout.
- Assert arst during W_ADDR and during R_VALID: outputs return to reset values immediately. No stray bvalid/rvalid after release; the next full write/read completes normally.
